row_clear_sequencer: RTL and testbench



---
 rtl/row_clear_if.sv | 27 ++
 rtl/row_clear_sequencer.sv | 117 +++++++++++
 tb/tb_row_clear_sequencer.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/row_clear_if.sv
// row_clear_if: controller/display bundle for row_clear_sequencer; score exists only with ROW_CLEAR_SCORE_EN.
interface row_clear_if #(
  parameter int COLS  = 10,
  parameter int ROWS  = 20,
  parameter int CNT_W = 5
);
  logic                 start;
  logic                 frame_tick;
  logic                 busy;
  logic                 done;
  logic [ROWS*COLS-1:0] board_in;
  logic [ROWS*COLS-1:0] board_out;
  logic [ROWS*COLS-1:0] flash;
  logic [CNT_W-1:0]     lines_cleared;
`ifdef ROW_CLEAR_SCORE_EN
  logic [15:0]          score;
  modport master (output start, board_in, frame_tick,
                  input  busy, done, board_out, flash, lines_cleared, score);
  modport slave  (input  start, board_in, frame_tick,
                  output busy, done, board_out, flash, lines_cleared, score);
`else
  modport master (output start, board_in, frame_tick,
                  input  busy, done, board_out, flash, lines_cleared);
  modport slave  (input  start, board_in, frame_tick,
                  output busy, done, board_out, flash, lines_cleared);
`endif
endinterface

// File: rtl/row_clear_sequencer.sv
// row_clear_sequencer: detects full rows, blinks them, collapses the board; ROW_CLEAR_SCORE_EN adds a score accumulator.
module row_clear_sequencer #(
  parameter int COLS          = 10,
  parameter int ROWS          = 20,
  parameter int FLASH_FRAMES  = 8,
  parameter int FLASH_TOGGLES = 6,
  parameter int CNT_W         = 5
) (
  input logic     clk,
  input logic     clrn,
  row_clear_if.slave bus
);
  localparam int FW = $clog2(FLASH_FRAMES) + 1;
  localparam int PW = $clog2(FLASH_TOGGLES) + 1;
  localparam logic [FW-1:0] F_LAST = FW'(FLASH_FRAMES - 1);
  localparam logic [PW-1:0] P_LAST = PW'(FLASH_TOGGLES - 1);
  typedef enum logic [2:0] {IDLE, SCAN, FLASH, COLLAPSE, DONE} state_t;
  state_t               state, state_n;
  logic [ROWS*COLS-1:0] board_q, board_n, board_sh, row_flash;
  logic [ROWS-1:0]      mask_q, mask_n, mask_sh, full;
  logic [FW-1:0]        fcnt, fcnt_n;
  logic [PW-1:0]        phase, phase_n;
  logic [CNT_W-1:0]     lines_q, lines_n, pop;
  int                   k;
  always_ff @(posedge clk) begin
    if (!clrn) begin
      state   <= IDLE;
      board_q <= '0;
      mask_q  <= '0;
      fcnt    <= '0;
      phase   <= '0;
      lines_q <= '0;
    end else begin
      state   <= state_n;
      board_q <= board_n;
      mask_q  <= mask_n;
      fcnt    <= fcnt_n;
      phase   <= phase_n;
      lines_q <= lines_n;
    end
  end
  // k is the lowest full row on screen; everything from row 0 down to k drops by one
  always_comb begin
    full      = '0;
    pop       = '0;
    k         = 0;
    row_flash = '0;
    for (int r = 0; r < ROWS; r++) begin
      full[r] = &board_q[r*COLS +: COLS];
      pop     = pop + CNT_W'(full[r]);
      row_flash[r*COLS +: COLS] = {COLS{mask_q[r]}};
      if (mask_q[r]) k = r;
    end
    board_sh          = board_q;
    mask_sh           = mask_q;
    board_sh[COLS-1:0] = '0;
    mask_sh[0]        = 1'b0;
    for (int r = 1; r < ROWS; r++) begin
      board_sh[r*COLS +: COLS] = r > k ? board_q[r*COLS +: COLS] : board_q[(r-1)*COLS +: COLS];
      mask_sh[r]               = r > k ? mask_q[r] : mask_q[r-1];
    end
  end
  always_comb begin
    state_n = state;
    board_n = board_q;
    mask_n  = mask_q;
    fcnt_n  = fcnt;
    phase_n = phase;
    lines_n = lines_q;
    unique case (state)
      IDLE: if (bus.start) begin
        state_n = SCAN;
        board_n = bus.board_in;
        lines_n = '0;
      end
      SCAN: begin
        mask_n  = full;
        fcnt_n  = '0;
        phase_n = '0;
        state_n = full == '0 ? DONE : FLASH;
        lines_n = full == '0 ? lines_q : pop;
      end
      FLASH: if (bus.frame_tick) begin
        fcnt_n  = fcnt == F_LAST ? '0 : fcnt + 1'b1;
        phase_n = fcnt == F_LAST && phase != P_LAST ? phase + 1'b1 : phase;
        state_n = fcnt == F_LAST && phase == P_LAST ? COLLAPSE : FLASH;
      end
      COLLAPSE: begin
        board_n = board_sh;
        mask_n  = mask_sh;
        state_n = mask_sh == '0 ? DONE : COLLAPSE;
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  assign bus.busy          = state == SCAN || state == FLASH || state == COLLAPSE;
  assign bus.done          = state == DONE;
  assign bus.board_out     = board_q;
  assign bus.lines_cleared = lines_q;
  assign bus.flash         = state == FLASH && !phase[0] ? row_flash : '0;
`ifdef ROW_CLEAR_SCORE_EN
  logic [15:0] score;
  logic [3:0]  add;
  logic [16:0] sum;
  always_comb begin
    add = lines_q == CNT_W'(1) ? 4'd1 : lines_q == CNT_W'(2) ? 4'd3 :
          lines_q == CNT_W'(3) ? 4'd5 : lines_q >= CNT_W'(4) ? 4'd8 : 4'd0;
    sum = {1'b0, score} + {13'd0, add};
  end
  always_ff @(posedge clk) begin
    if (!clrn) score <= '0;
    else if (state == DONE) score <= sum[16] ? 16'hFFFF : sum[15:0];
  end
  assign bus.score = score;
`endif
endmodule

// File: tb/tb_row_clear_sequencer.sv
// tb_row_clear_sequencer: random and directed row-clear operations checked against a row-packing reference model.
module tb_row_clear_sequencer;
  localparam int COLS = 10, ROWS = 20, N = COLS * ROWS, TICKS = 48;
  logic clk = 1'b0;
  logic clrn = 1'b0;
  int total = 0, bad = 0;
  int unsigned score_exp = 0;
  row_clear_if #(.COLS(COLS), .ROWS(ROWS), .CNT_W(5)) bus ();
  row_clear_sequencer #(.COLS(COLS), .ROWS(ROWS), .FLASH_FRAMES(8), .FLASH_TOGGLES(6), .CNT_W(5))
    dut (.clk(clk), .clrn(clrn), .bus(bus.slave));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [N-1:0] got, input logic [N-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  // Reference: full rows vanish, remaining rows keep their order and settle at the bottom.
  function automatic void model(input logic [N-1:0] b, output logic [N-1:0] fin,
                                output logic [N-1:0] fm, output int n);
    logic [COLS-1:0] row;
    int w;
    w = ROWS - 1;
    fin = '0;
    fm = '0;
    n = 0;
    for (int r = ROWS - 1; r >= 0; r--) begin
      row = b[r*COLS +: COLS];
      if (row == {COLS{1'b1}}) begin
        n++;
        fm[r*COLS +: COLS] = '1;
      end else begin
        fin[w*COLS +: COLS] = row;
        w--;
      end
    end
  endfunction
  function automatic logic [N-1:0] flash_exp(input int ticks, input logic [N-1:0] fm);
    return ticks < TICKS && (ticks / 8) % 2 == 0 ? fm : '0;
  endfunction
  task automatic check_score();
`ifdef ROW_CLEAR_SCORE_EN
    check("score", N'(bus.score), N'(score_exp));
`endif
  endtask
  task automatic run_op(input string name, input logic [N-1:0] b);
    logic [N-1:0] fin, fm;
    int n, c;
    int add[5] = '{0, 1, 3, 5, 8};
    model(b, fin, fm, n);
    bus.board_in = b;
    bus.start = 1'b1;
    bus.frame_tick = 1'($urandom_range(0, 1));
    step();
    bus.start = 1'b0;
    bus.board_in = ~b;
    bus.frame_tick = 1'($urandom_range(0, 1));
    check({name, " busy_scan"}, N'(bus.busy), N'(1));
    check({name, " flash_scan"}, bus.flash, '0);
    step();
    bus.frame_tick = 1'b0;
    if (n == 0) begin
      check({name, " done_lat2"}, N'(bus.done), N'(1));
    end else begin
      check({name, " lines_flash"}, N'(bus.lines_cleared), N'(n));
      check({name, " flash_t0"}, bus.flash, flash_exp(0, fm));
      for (int t = 1; t <= TICKS; t++) begin
        repeat ($urandom_range(0, 2)) begin
          bus.start = 1'($urandom_range(0, 1));
          step();
          bus.start = 1'b0;
          check({name, " flash_gap"}, bus.flash, flash_exp(t - 1, fm));
        end
        bus.frame_tick = 1'b1;
        step();
        bus.frame_tick = 1'b0;
        check({name, " flash_tick"}, bus.flash, flash_exp(t, fm));
        check({name, " busy_flash"}, N'(bus.busy), N'(1));
      end
      c = 0;
      while (!bus.done && c < 64) begin
        bus.frame_tick = 1'($urandom_range(0, 1));
        step();
        c++;
      end
      bus.frame_tick = 1'b0;
      check({name, " collapse_cycles"}, N'(c), N'(n));
      check({name, " done"}, N'(bus.done), N'(1));
    end
    check({name, " board_done"}, bus.board_out, fin);
    check({name, " lines_done"}, N'(bus.lines_cleared), N'(n));
    check({name, " busy_done"}, N'(bus.busy), N'(0));
    check({name, " flash_done"}, bus.flash, '0);
    score_exp += add[n > 4 ? 4 : n];
    if (score_exp > 32'hFFFF) score_exp = 32'hFFFF;
    step();
    check({name, " done_pulse"}, N'(bus.done), N'(0));
    check({name, " board_hold"}, bus.board_out, fin);
    check_score();
  endtask
  task automatic reset_mid();
    logic [N-1:0] b, fin, fm;
    int n, dones;
    b = '0;
    b[19*COLS +: COLS] = '1;
    b[5*COLS +: COLS] = 10'h2AB;
    model(b, fin, fm, n);
    bus.board_in = b;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    step();
    for (int t = 1; t <= 20; t++) begin
      bus.frame_tick = 1'b1;
      step();
      bus.frame_tick = 1'b0;
    end
    check("rst flash_before", bus.flash, flash_exp(20, fm));
    clrn = 1'b0;
    step();
    clrn = 1'b1;
    score_exp = 0;
    check("rst busy", N'(bus.busy), N'(0));
    check("rst flash", bus.flash, '0);
    check("rst board", bus.board_out, '0);
    check("rst lines", N'(bus.lines_cleared), N'(0));
    check("rst done", N'(bus.done), N'(0));
    check_score();
    dones = 0;
    repeat (80) begin
      bus.frame_tick = 1'($urandom_range(0, 1));
      step();
      dones += int'(bus.done) + int'(bus.busy);
    end
    bus.frame_tick = 1'b0;
    check("rst no_done", N'(dones), N'(0));
  endtask
  initial begin
    logic [N-1:0] b;
    int p;
    bus.start = 1'b0;
    bus.frame_tick = 1'b0;
    bus.board_in = '0;
    repeat (3) step();
    check("reset busy", N'(bus.busy), N'(0));
    check("reset done", N'(bus.done), N'(0));
    check("reset board", bus.board_out, '0);
    check("reset flash", bus.flash, '0);
    check("reset lines", N'(bus.lines_cleared), N'(0));
    check_score();
    clrn = 1'b1;
    step();
    b = '0; b[19*COLS +: COLS] = 10'b1111111110;
    run_op("none", b);
    b = '0; b[19*COLS +: COLS] = '1; b[18*COLS +: COLS] = 10'b0000000001;
    run_op("single", b);
    b = '0; b[19*COLS +: COLS] = '1; b[17*COLS +: COLS] = '1;
    b[18*COLS +: COLS] = 10'h155; b[16*COLS +: COLS] = 10'h0AA;
    run_op("nonadj", b);
    b = '0; b[16*COLS +: 4*COLS] = '1; b[15*COLS +: COLS] = 10'h3F0;
    run_op("four", b);
    reset_mid();
    b = '0; b[0 +: COLS] = '1;
    run_op("top", b);
    for (int i = 0; i < 6; i++) begin
      for (int r = 0; r < ROWS; r++) begin
        p = $urandom_range(0, 99);
        b[r*COLS +: COLS] = p < 30 ? {COLS{1'b1}} : p < 55 ? {COLS{1'b0}} : COLS'($urandom);
      end
      run_op($sformatf("rand%0d", i), b);
    end
    b = '1;
    run_op("all_full", b);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
